// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// M-stage store buffer. Stores are queued in a small FIFO and drained to the
// data memory in the background. Loads share the single memory port. A load
// that matches a pending store's word address stalls the core until that
// store has been committed. A store into a full buffer also stalls the core.
// The buffer never forwards data to loads, and stores commit in program order.
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWriteM,
    input  logic          MemReadM,
    input  logic [2:0]    funct3M,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallM,
    output logic          Empty,
    output logic          mem_WE,
    output logic [2:0]    mem_funct3,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    input  logic [DW-1:0] mem_RD,
    input  logic          mem_wready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry storage, deliberately left without reset.
    logic [AW-1:0] a_mem  [DEPTH];
    logic [DW-1:0] wd_mem [DEPTH];
    logic [2:0]    f3_mem [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic             is_store_s;
    logic             is_load_s;
    logic             full_s;
    logic             empty_s;
    logic [DEPTH-1:0] valid_s;
    logic             hazard_s;
    logic             load_port_s;
    logic             drain_s;
    logic             push_s;
    logic             pop_s;

    // Decode the M-stage op; a store wins over a simultaneous load request.
    always_comb begin
        is_store_s = MemWriteM;
        is_load_s  = !MemWriteM && MemReadM;
        full_s     = (count_r == FULL_COUNT);
        empty_s    = (count_r == {CW{1'b0}});
    end

    // Mark which slots hold pending stores (distance from the head < count).
    always_comb begin
        logic [PW-1:0] off;
        off     = {PW{1'b0}};
        valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - rd_ptr_r;
            valid_s[i] = ({1'b0, off} < count_r);
        end
    end

    // Word-granular compare of the load address against every pending store.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i] && (a_mem[i][AW-1:2] == ALUResultM[AW-1:2])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        hazard_s = hazard_s && is_load_s;
    end

    // Port arbitration: clean load first, otherwise drain the head entry.
    always_comb begin
        load_port_s = 1'b0;
        drain_s     = 1'b0;
        if (reset) begin
            load_port_s = 1'b0;
            drain_s     = 1'b0;
        end else if (is_load_s && !hazard_s) begin
            load_port_s = 1'b1;
        end else if (!empty_s) begin
            drain_s = 1'b1;
        end else begin
            drain_s = 1'b0;
        end
    end

    // Drive the memory port and the core-facing outputs.
    always_comb begin
        mem_WE     = 1'b0;
        mem_A      = {AW{1'b0}};
        mem_WD     = {DW{1'b0}};
        mem_funct3 = 3'b000;
        ReadDataM  = {DW{1'b0}};
        if (load_port_s) begin
            mem_A      = ALUResultM;
            mem_funct3 = funct3M;
            ReadDataM  = mem_RD;
        end else if (drain_s) begin
            mem_WE     = 1'b1;
            mem_A      = a_mem[rd_ptr_r];
            mem_WD     = wd_mem[rd_ptr_r];
            mem_funct3 = f3_mem[rd_ptr_r];
        end else begin
            mem_WE = 1'b0;
        end
        if (reset) begin
            StallM = 1'b0;
        end else begin
            StallM = hazard_s || (is_store_s && full_s);
        end
        Empty = empty_s;
    end

    // Enqueue when a store meets a non-full buffer; pop on a committed write.
    always_comb begin
        push_s = is_store_s && !full_s && !reset;
        pop_s  = mem_WE && mem_wready;
    end

    // Write the accepted store into the tail slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            a_mem[wr_ptr_r]  <= ALUResultM;
            wd_mem[wr_ptr_r] <= WriteDataM;
            f3_mem[wr_ptr_r] <= funct3M;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
